// File: rtl/muldiv_sequencer.sv
// Iterative MUL/DIV/REM sequencer beside the EX-stage ALU.
// MULDIV_FAST_MUL_EN: single-cycle MUL via a combinational multiplier.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_REM = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_op;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_rec;
  logic             w_accept;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0] w_prod;
  assign w_prod = src_a * src_b;
`endif

  always_comb begin
    w_rec    = (op == OP_MUL) | (op == OP_DIV) | (op == OP_REM);
    w_accept = (r_state == S_IDLE) & start & w_rec & ~kill;
    w_sa     = src_a[WIDTH-1];
    w_sb     = src_b[WIDTH-1];
    w_abs_a  = w_sa ? (~src_a + WIDTH'(1)) : src_a;
    w_abs_b  = w_sb ? (~src_b + WIDTH'(1)) : src_b;
    w_div0   = (src_b == '0);
    w_ovf    = (src_a == {1'b1, {(WIDTH-1){1'b0}}}) &
               (src_b == {WIDTH{1'b1}});
    w_special  = (op != OP_MUL) & (w_div0 | w_ovf);
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = (op == OP_DIV) ? {WIDTH{1'b1}} : src_a;
    else if (w_ovf)
      w_spec_res = (op == OP_DIV) ? src_a : '0;
`ifdef MULDIV_FAST_MUL_EN
    if (op == OP_MUL) begin
      w_special  = 1'b1;
      w_spec_res = w_prod;
    end
`endif
    // Restoring divide step: r_a shifts the dividend out, quotient in
    w_shift = {r_rem, r_a[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_b};
    w_mag   = (r_op == OP_MUL) ? r_acc :
              (r_op == OP_DIV) ? r_a : r_rem;
    w_fix   = r_neg ? (~w_mag + WIDTH'(1)) : w_mag;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept)
          w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:
        if (kill)
          w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(1))
          w_state_nxt = S_FIX;
      S_FIX:
        w_state_nxt = kill ? S_IDLE : S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_CALC) | (w_state_nxt == S_FIX);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_op  <= op;
            r_neg <= (op == OP_REM) ? w_sa : (w_sa ^ w_sb);
            r_a   <= w_abs_a;
            r_b   <= w_abs_b;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= CW'(WIDTH);
            if (w_special)
              r_result <= w_spec_res;
          end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_op == OP_MUL) begin
            if (r_b[0])
              r_acc <= r_acc + r_a;
            r_a <= {r_a[WIDTH-2:0], 1'b0};
            r_b <= {1'b0, r_b[WIDTH-1:1]};
          end else begin
            r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0]
                                    : w_trial[WIDTH-1:0];
            r_a   <= {r_a[WIDTH-2:0], ~w_trial[WIDTH]};
          end
        end
        S_FIX:
          if (!kill)
            r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign stall  = w_accept | (r_state == S_CALC) | (r_state == S_FIX);
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_REM = 4'b0100;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_pass = 0;
  int n_tot  = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .kill  (kill),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Issue one op at cycle 0 and follow it to its done strobe.
  task automatic run(input string nm, input logic [3:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] exp);
    int c;
    int bad;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    chk({nm, ".stall0"}, 32'(stall), 32'd1);
    chk({nm, ".done0"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    c = 0; bad = 0; got = 1'b0;
    while (!got && c < 60) begin
      c++;
      @(negedge clk);
      if (done) got = 1'b1;
      else if (!stall) bad++;
    end
    chk({nm, ".got_done"}, 32'(got), 32'd1);
    chk({nm, ".latency"}, 32'(c), 32'(lat));
    chk({nm, ".result"}, result, exp);
    chk({nm, ".stall_hold"}, 32'(bad), 32'd0);
    chk({nm, ".done_stall"}, {30'd0, stall, busy}, 32'd0);
  endtask

  vec_t vt[$];
  logic [31:0] held;
  int nd;

  initial begin
    vt.push_back('{OP_MUL, 32'd7, 32'hFFFFFFFD, MLAT, 32'hFFFFFFEB});
    vt.push_back('{OP_DIV, 32'hFFFFFFEC, 32'd3, 34, 32'hFFFFFFFA});
    vt.push_back('{OP_REM, 32'hFFFFFFEC, 32'd3, 34, 32'hFFFFFFFE});
    vt.push_back('{OP_DIV, 32'd5, 32'd0, 1, 32'hFFFFFFFF});
    vt.push_back('{OP_REM, 32'd5, 32'd0, 1, 32'd5});
    vt.push_back('{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000});
    vt.push_back('{OP_REM, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0});
    vt.push_back('{OP_DIV, 32'd100, 32'd7, 34, 32'd14});
    vt.push_back('{OP_MUL, 32'h00010000, 32'h00010000, MLAT, 32'd0});
    vt.push_back('{OP_MUL, 32'hFFFFFFFB, 32'hFFFFFFFA, MLAT, 32'd30});
    vt.push_back('{OP_REM, 32'd7, 32'hFFFFFFFE, 34, 32'd1});
    vt.push_back('{OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 32'hFFFFFFFD});
    vt.push_back('{OP_DIV, 32'h80000000, 32'd1, 34, 32'h80000000});
    vt.push_back('{OP_REM, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'd0});

    rst_n = 1'b0; start = 1'b0; op = '0;
    src_a = '0; src_b = '0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);

    foreach (vt[i])
      run($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
          vt[i].lat, vt[i].exp);

    // kill mid-DIV: abort, no done, result held
    held = result;
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(negedge clk);
    chk("kill.busy10", 32'(busy), 32'd1);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill.busy11", 32'(busy), 32'd0);
    chk("kill.stall11", 32'(stall), 32'd0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("kill.no_done", 32'(nd), 32'd0);
    chk("kill.result", result, held);
    run("kill.rerun", OP_DIV, 32'd100, 32'd7, 34, 32'd14);

    // reset in the middle of a MUL
    @(posedge clk); #1;
    start = 1'b1; op = OP_MUL; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.result", result, 32'd0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("mrst.no_done", 32'(nd), 32'd0);

    // back-to-back: MUL starts the cycle after REM's done
    run("b2b.rem", OP_REM, 32'd100, 32'd7, 34, 32'd2);
    run("b2b.mul", OP_MUL, 32'd6, 32'd7, MLAT, 32'd42);

    // unrecognised op is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 4'b0000; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    chk("badop.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("badop.busy", 32'(busy), 32'd0);
    chk("badop.done", 32'(done), 32'd0);
    chk("badop.result", result, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the M-extension ops the ALU control decodes: MUL (OP=4'b0010), DIV (4'b0011) and REM (4'b0100).
- Owns an iterative shift-add multiplier and a restoring divider, and runs them for WIDTH cycles.
- Stalls the pipeline while it works, then delivers a one-cycle result with a done strobe.
- Sits beside the single-cycle ALU in EX. EX muxes its result in on done.

Parameters:
- WIDTH, 32, operand/result width in bits; even, >=4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  EX has a valid instruction with an M-extension OP this cycle.
- op  in  4  ALU control OP code; only 4'b0010/0011/0100 are recognised.
- src_a  in  WIDTH  rs1 value (multiplicand/dividend), two's complement.
- src_b  in  WIDTH  rs2 value (multiplier/divisor), two's complement.
- kill  in  1  pipeline flush; aborts any operation in flight.
- stall  out  1  hold IF/ID/EX; combinational.
- busy  out  1  registered; high in CALC/FIX.
- done  out  1  registered one-cycle strobe; result valid.
- result  out  WIDTH  registered result; held until the next done.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; done=0; busy=0; result=0; internal counters and registers cleared.
  - Reset has priority over everything, including mid-operation; no done follows.
- States: IDLE, CALC, FIX, DONE. Iteration counter is $clog2(WIDTH)+1 bits.
- Accept: only in IDLE when start=1, kill=0 and op is recognised. Operands and op are latched.
  - start with an unrecognised op: ignored; stall=0.
  - start in any other state: ignored.
- Signed handling: latch |src_a| and |src_b|. Record the result sign:
  - MUL: sign_a^sign_b.
  - DIV: sign_a^sign_b.
  - REM: sign_a.
- Special cases, decided at accept; next state is DONE (done at cycle 1):
  - DIV by zero: quotient = all ones.
  - REM by zero: result = src_a.
  - DIV overflow (src_a = 1 followed by WIDTH-1 zeros, src_b = all ones): result = src_a.
  - REM overflow (same operands): result = 0.
- IDLE -> CALC on a normal accept; counter=WIDTH.
- CALC, one bit per cycle, counter decrements:
  - MUL: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift. Keep the low WIDTH bits.
  - DIV/REM: shift the remainder left, bringing in the dividend MSB. Trial-subtract the divisor; if non-negative, keep it and set the quotient bit.
  - Leave CALC when counter reaches 0.
- CALC -> FIX: apply the sign (two's-complement negate if the sign flag is set). Select quotient for DIV, remainder for REM, product low half for MUL. Load result.
- FIX -> DONE; DONE -> IDLE unconditionally.
  - done=1 only in DONE; busy=0 in DONE.
  - A start in the cycle after DONE (state IDLE) is accepted normally.
- Latency: accept at cycle 0, done at cycle WIDTH+2 (34 for WIDTH=32).
- stall = (state==IDLE & start & recognised op & ~kill) | (state==CALC) | (state==FIX).
  - stall=0 in DONE, so EX captures the result while the pipeline advances.
- kill:
  - In CALC/FIX: next state IDLE, no done, result unchanged.
  - In DONE: done still completes; the pipeline discards it.
  - In IDLE: blocks accept.
- result updates only on entry to DONE; otherwise it holds its previous value.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL bypasses CALC/FIX. The result is the low WIDTH bits of the combinational src_a*src_b, loaded at accept, with done at cycle 1. DIV/REM are unchanged.
- Undefined: MUL uses the iterative path with WIDTH+2 latency, and no multiplier operator is inferred.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD (-3), WIDTH=32 -> stall high cycles 0-33, done at cycle 34, result=0xFFFFFFEB. With MULDIV_FAST_MUL_EN: done at cycle 1, same result.
- DIV src_a=0xFFFFFFEC (-20), src_b=3 -> result=0xFFFFFFFA (-6) at cycle 34. REM with the same operands -> result=0xFFFFFFFE (-2).
- DIV 5/0 -> done at cycle 1, result=0xFFFFFFFF. REM 5/0 -> result=5. DIV 0x80000000/0xFFFFFFFF -> result=0x80000000. REM with the same operands -> result=0.
- DIV 100/7 with kill=1 at cycle 10 -> state IDLE at cycle 11, no done, result keeps its prior value. A new DIV 100/7 then gives done at cycle 34 with result=14.
- rst_n=0 at cycle 5 of MUL 3*4 -> done=0, busy=0, result=0 next cycle, no done afterwards.
- Back-to-back: REM 100/7 then MUL 6*7 started the cycle after DONE -> results 2, then 42, with no lost or duplicate done. start with op=4'b0000 -> ignored, stall=0.
